hex_digit_scanner: RTL

//  Upstream feeder for the 4-bit hex-to-7-segment decoder. Holds a DIGITS-nibble display value and

---
 rtl/hex_digit_scanner.sv | 105 ++++++++++
 1 files changed

// File: rtl/hex_digit_scanner.sv
// Scans a DIGITS-nibble display value onto a shared 4-bit decoder bus with active-low digit enables.
// Latency: outputs are registered and follow idx/disp_reg changes by one cycle.
// Backpressure: none; load is a one-cycle strobe, always accepted, newest value wins; en=0 freezes the scan.
module hex_digit_scanner #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 50000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            digit_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          div_cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    disp_reg;
    logic [4*DIGITS-1:0]    pend_reg;
    logic                   pend_valid;

    logic                   adv;
    logic                   wrap;
    logic [DIGITS-1:0]      upper_zero;
    logic                   blank;
    logic [3:0]             cur_nibble;

    // Scan step decode: adv moves to the next digit, wrap closes the frame.
    always_comb begin
        adv  = en && (div_cnt == DIV_LAST);
        wrap = adv && (idx == IDX_LAST);
    end

    // upper_zero[i] = nibbles i..DIGITS-1 of the displayed value are all zero.
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (disp_reg[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_reg[4*i +: 4] == 4'h0);
        end
        // Digit 0 always lights so a zero value still shows one "0".
        blank      = LZ_BLANK && (idx != '0) && upper_zero[idx];
        cur_nibble = disp_reg[4*idx +: 4];
    end

    // Divider and digit index; both hold while en is low so a pause resumes in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (en) begin
            if (adv) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Double buffer: pending value commits at the frame wrap; a load on the wrap edge bypasses it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                disp_reg <= value;
            end else if (pend_valid) begin
                disp_reg <= pend_reg;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_reg   <= value;
            pend_valid <= 1'b1;
        end
    end

    // Registered outputs from the current idx/disp_reg; digit_out holds while the scan is paused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_out  <= 4'h0;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (en) begin
                digit_out <= cur_nibble;
                an        <= blank ? '1 : ~(DIGITS'(1) << idx);
            end else begin
                an        <= '1;
            end
        end
    end

endmodule
